// File: rtl/alu_issue_ctrl_pkg.sv
// Shared constants for the ALU issue controller: word size, ALU function codes and FSM states.
package alu_issue_ctrl_pkg;

  localparam int WORD_SIZE = 16;
  localparam int CODE_W    = 4;

  localparam logic [CODE_W-1:0] FUNC_ADD = 4'd0;
  localparam logic [CODE_W-1:0] FUNC_SUB = 4'd1;
  localparam logic [CODE_W-1:0] FUNC_AND = 4'd2;
  localparam logic [CODE_W-1:0] FUNC_ORR = 4'd3;
  localparam logic [CODE_W-1:0] FUNC_NOT = 4'd4;
  localparam logic [CODE_W-1:0] FUNC_TCP = 4'd5;
  localparam logic [CODE_W-1:0] FUNC_SHL = 4'd6;
  localparam logic [CODE_W-1:0] FUNC_SHR = 4'd7;
  localparam logic [CODE_W-1:0] FUNC_LHI = 4'd8;
  localparam logic [CODE_W-1:0] FUNC_IDA = 4'd9;
  localparam logic [CODE_W-1:0] FUNC_IDB = 4'd10;

  localparam logic [CODE_W-1:0] ALU_CODE_MAX = FUNC_IDB;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_WAIT_ACK,
    ST_RELEASE,
    ST_RESULT
  } issueState_e;

  function automatic logic isLegalCode(input logic [CODE_W-1:0] code);
    return code <= ALU_CODE_MAX;
  endfunction

endpackage

// File: rtl/alu_req_fifo.sv
// Small synchronous request FIFO; pointers carry one extra wrap bit to separate full from empty.
module alu_req_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wrData,
  output logic [WIDTH-1:0] rdData,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wrPtr;
  logic [AW:0]      rdPtr;

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + (AW+1)'(1);
      if (pop)  rdPtr <= rdPtr + (AW+1)'(1);
    end
  end

  // NOTE: storage is not reset; full/empty come from the pointers, so stale entries are never read.
  always_ff @(posedge clk) begin
    if (push) mem[wrPtr[AW-1:0]] <= wrData;
  end

  assign rdData = mem[rdPtr[AW-1:0]];
  assign empty  = (wrPtr == rdPtr);
  assign full   = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);

endmodule

// File: rtl/alu_issue_ctrl.sv
// Initiator side of the ALU alu_ready/alu_complete handshake: queues requests, issues them one
// at a time, captures the result and holds it for the consumer.
module alu_issue_ctrl #(
  parameter int WORD_SIZE  = alu_issue_ctrl_pkg::WORD_SIZE,
  parameter int FIFO_DEPTH = 2,
  parameter int TIMEOUT    = 15
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [WORD_SIZE-1:0] req_a,
  input  logic [WORD_SIZE-1:0] req_b,
  input  logic [3:0]           req_code,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [WORD_SIZE-1:0] res_data,
  output logic                 res_err,
  output logic [WORD_SIZE-1:0] alu_a,
  output logic [WORD_SIZE-1:0] alu_b,
  output logic [3:0]           alu_code,
  output logic                 alu_ready,
  input  logic                 alu_complete,
  input  logic [WORD_SIZE-1:0] alu_c,
  output logic                 busy
);

  import alu_issue_ctrl_pkg::*;

  localparam int REQ_W = 2*WORD_SIZE + CODE_W;
  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [REQ_W-1:0]     headReq;
  logic [WORD_SIZE-1:0] headA, headB;
  logic [CODE_W-1:0]    headCode;
  logic                 fifoFull, fifoEmpty, popReq, launch;

  issueState_e          state, stateNext;
  logic [CNT_W-1:0]     count, countNext;
  logic [WORD_SIZE-1:0] aluA, aluANext, aluB, aluBNext, resData, resDataNext;
  logic [CODE_W-1:0]    aluCode, aluCodeNext;
  logic                 aluReady, aluReadyNext, resErr, resErrNext;

  assign {headA, headB, headCode} = headReq;

  alu_req_fifo #(
    .WIDTH (REQ_W),
    .DEPTH (FIFO_DEPTH)
  ) reqFifo (
    .clk    (clk),
    .reset_n(reset_n),
    .push   (req_valid && !fifoFull),
    .pop    (popReq),
    .wrData ({req_a, req_b, req_code}),
    .rdData (headReq),
    .full   (fifoFull),
    .empty  (fifoEmpty)
  );

  // A new request is taken from IDLE, or straight out of RESULT as the consumer accepts.
  assign launch = !fifoEmpty && ((state == ST_IDLE) || ((state == ST_RESULT) && res_ready));

  always_comb begin
    // NOTE: every next value defaults to the current one first, so no branch can infer a latch.
    stateNext    = state;
    countNext    = count;
    aluANext     = aluA;
    aluBNext     = aluB;
    aluCodeNext  = aluCode;
    aluReadyNext = aluReady;
    resDataNext  = resData;
    resErrNext   = resErr;
    popReq       = 1'b0;

    case (state)
      ST_IDLE: ;
      ST_SETUP: begin
        stateNext    = ST_WAIT_ACK;
        aluReadyNext = 1'b1;
        countNext    = '0;
      end
      ST_WAIT_ACK: begin
        if (alu_complete) begin
          resDataNext  = alu_c;
          resErrNext   = 1'b0;
          aluReadyNext = 1'b0;
          countNext    = '0;
          stateNext    = ST_RELEASE;
        end else if (count == CNT_LAST) begin
          resDataNext  = '0;
          resErrNext   = 1'b1;
          aluReadyNext = 1'b0;
          countNext    = '0;
          stateNext    = ST_RELEASE;
        end else begin
          countNext = count + CNT_W'(1);
        end
      end
      ST_RELEASE: begin
        if (!alu_complete) begin
          stateNext = ST_RESULT;
        end else if (count == CNT_LAST) begin
          resErrNext = 1'b1;
          stateNext  = ST_RESULT;
        end else begin
          countNext = count + CNT_W'(1);
        end
      end
      ST_RESULT: begin
        if (res_ready) stateNext = ST_IDLE;
      end
      default: stateNext = ST_IDLE;
    endcase

    if (launch) begin
      popReq = 1'b1;
      if (isLegalCode(headCode)) begin
        aluANext    = headA;
        aluBNext    = headB;
        aluCodeNext = headCode;
        stateNext   = ST_SETUP;
      end else begin
        resDataNext = '0;
        resErrNext  = 1'b1;
        stateNext   = ST_RESULT;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      count    <= '0;
      aluA     <= '0;
      aluB     <= '0;
      aluCode  <= '0;
      aluReady <= 1'b0;
      resData  <= '0;
      resErr   <= 1'b0;
    end else begin
      state    <= stateNext;
      count    <= countNext;
      aluA     <= aluANext;
      aluB     <= aluBNext;
      aluCode  <= aluCodeNext;
      aluReady <= aluReadyNext;
      resData  <= resDataNext;
      resErr   <= resErrNext;
    end
  end

  assign req_ready = !fifoFull;
  assign res_valid = (state == ST_RESULT);
  assign res_data  = resData;
  assign res_err   = resErr;
  assign alu_a     = aluA;
  assign alu_b     = aluB;
  assign alu_code  = aluCode;
  assign alu_ready = aluReady;
  assign busy      = (state != ST_IDLE) || !fifoEmpty;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU whose acknowledge style is selectable.
module tb_alu_issue_ctrl;

  import alu_issue_ctrl_pkg::*;

  localparam int W = 16;

  logic         clk, reset_n;
  logic         req_valid, req_ready, res_valid, res_ready, res_err;
  logic [W-1:0] req_a, req_b, res_data, alu_a, alu_b, alu_c;
  logic [3:0]   req_code, alu_code;
  logic         alu_ready, alu_complete, busy;

  alu_issue_ctrl #(.WORD_SIZE(W), .FIFO_DEPTH(2), .TIMEOUT(15)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_code(req_code),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_err(res_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_code(alu_code),
    .alu_ready(alu_ready), .alu_complete(alu_complete), .alu_c(alu_c),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Behavioural ALU: one-cycle ack pulse, never acks, or holds ack 4 cycles after alu_ready drops.
  typedef enum {ACK_PULSE, ACK_NEVER, ACK_HOLD} ackMode_e;
  ackMode_e ackMode = ACK_PULSE;
  int       holdCnt;

  always @(posedge clk) begin
    if (!reset_n) begin
      alu_complete <= 1'b0;
      holdCnt      <= 0;
    end else begin
      case (ackMode)
        ACK_PULSE: alu_complete <= alu_ready && !alu_complete;
        ACK_NEVER: alu_complete <= 1'b0;
        default: begin
          if (alu_ready) begin
            alu_complete <= 1'b1;
            holdCnt      <= 4;
          end else if (holdCnt > 1) begin
            holdCnt <= holdCnt - 1;
          end else begin
            alu_complete <= 1'b0;
            holdCnt      <= 0;
          end
        end
      endcase
    end
  end

  always_comb begin
    alu_c = '0;
    case (alu_code)
      FUNC_ADD: alu_c = alu_a + alu_b;
      FUNC_SUB: alu_c = alu_a - alu_b;
      FUNC_AND: alu_c = alu_a & alu_b;
      FUNC_ORR: alu_c = alu_a | alu_b;
      FUNC_NOT: alu_c = ~alu_a;
      FUNC_TCP: alu_c = ~alu_a + 16'd1;
      FUNC_SHL: alu_c = {alu_a[14:0], 1'b0};
      FUNC_SHR: alu_c = {alu_a[15], alu_a[15:1]};
      FUNC_LHI: alu_c = {alu_b[7:0], 8'h00};
      FUNC_IDA: alu_c = alu_a;
      FUNC_IDB: alu_c = alu_b;
      default:  alu_c = '0;
    endcase
  end

  // Handshake monitor: cycles with alu_ready high, rising edges, and rises while ack still high.
  int   readyHighCnt = 0, readyRiseCnt = 0, badRiseCnt = 0;
  logic prevReady = 1'b0;
  always @(posedge clk) begin
    if (alu_ready) readyHighCnt++;
    if (alu_ready && !prevReady) begin
      readyRiseCnt++;
      if (alu_complete) badRiseCnt++;
    end
    prevReady = alu_ready;
  end

  int tests = 0, fails = 0;
  int pushCyc, resCyc;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Called at a negedge; returns at the negedge after the push edge.
  task automatic pushOp(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] code);
    int n = 0;
    req_a = a; req_b = b; req_code = code; req_valid = 1'b1;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    @(negedge clk);
    pushCyc = cyc;
  endtask

  task automatic waitResult(input string name);
    int n = 0;
    while (!res_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    resCyc = cyc;
    if (!res_valid) check({name, " res_valid within bound"}, res_valid, 1);
  endtask

  task automatic acceptResult();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic getResult(input string name, input logic [W-1:0] expData, input logic expErr);
    waitResult(name);
    check({name, " data"}, res_data, expData);
    check({name, " err"}, res_err, expErr);
    acceptResult();
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   code;
    logic [W-1:0] expData;
    logic         expErr;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int base, rises, badBase, t0;

    vecs[0]  = '{16'h0003, 16'h0004, FUNC_ADD, 16'h0007, 1'b0};
    vecs[1]  = '{16'h0005, 16'h0007, FUNC_SUB, 16'hFFFE, 1'b0};
    vecs[2]  = '{16'hF0F0, 16'h3C3C, FUNC_AND, 16'h3030, 1'b0};
    vecs[3]  = '{16'hF0F0, 16'h0F00, FUNC_ORR, 16'hFFF0, 1'b0};
    vecs[4]  = '{16'h00FF, 16'h1111, FUNC_NOT, 16'hFF00, 1'b0};
    vecs[5]  = '{16'h0001, 16'h0000, FUNC_TCP, 16'hFFFF, 1'b0};
    vecs[6]  = '{16'h4001, 16'h0000, FUNC_SHL, 16'h8002, 1'b0};
    vecs[7]  = '{16'h8002, 16'h0000, FUNC_SHR, 16'hC001, 1'b0};
    vecs[8]  = '{16'h0000, 16'h00AB, FUNC_LHI, 16'hAB00, 1'b0};
    vecs[9]  = '{16'h1234, 16'h5678, FUNC_IDA, 16'h1234, 1'b0};
    vecs[10] = '{16'h1234, 16'h5678, FUNC_IDB, 16'h5678, 1'b0};
    vecs[11] = '{16'h1234, 16'h5678, 4'd15,    16'h0000, 1'b1};

    reset_n = 1'b0; req_valid = 1'b0; res_ready = 1'b0;
    req_a = '0; req_b = '0; req_code = '0;
    repeat (3) @(negedge clk);

    check("reset alu_ready", alu_ready, 0);
    check("reset res_valid", res_valid, 0);
    check("reset busy", busy, 0);
    check("reset res_data", res_data, 0);
    check("reset res_err", res_err, 0);
    check("reset alu_a", alu_a, 0);
    check("reset req_ready", req_ready, 1);

    reset_n = 1'b1;
    @(negedge clk);

    // Single ADD: latency and alu_ready width.
    base = readyHighCnt;
    pushOp(16'h0003, 16'h0004, FUNC_ADD);
    req_valid = 1'b0;
    check("add busy", busy, 1);
    waitResult("add");
    check("add latency", resCyc - pushCyc, 5);
    check("add alu_ready cycles", readyHighCnt - base, 2);
    check("add data", res_data, 16'h0007);
    check("add err", res_err, 0);
    acceptResult();
    check("add idle after accept", busy, 0);

    for (int i = 0; i < 12; i++) begin
      pushOp(vecs[i].a, vecs[i].b, vecs[i].code);
      req_valid = 1'b0;
      getResult($sformatf("vec%0d", i), vecs[i].expData, vecs[i].expErr);
    end

    // Three back-to-back pushes with a stalled consumer.
    pushOp(16'h0005, 16'h0007, FUNC_SUB);
    pushOp(16'h8002, 16'h0000, FUNC_SHR);
    pushOp(16'h0000, 16'h00AB, FUNC_LHI);
    req_valid = 1'b0;
    check("b2b req_ready full", req_ready, 0);
    waitResult("b2b first");
    repeat (5) @(negedge clk);
    check("b2b stall res_valid", res_valid, 1);
    check("b2b stall data", res_data, 16'hFFFE);
    check("b2b stall req_ready", req_ready, 0);
    acceptResult();
    getResult("b2b shr", 16'hC001, 1'b0);
    getResult("b2b lhi", 16'hAB00, 1'b0);

    // Illegal code is never issued to the ALU.
    rises = readyRiseCnt;
    pushOp(16'h0001, 16'h0002, 4'd12);
    req_valid = 1'b0;
    getResult("illegal", 16'h0000, 1'b1);
    check("illegal no alu_ready", readyRiseCnt - rises, 0);

    // ALU never acks: timeout, then the next queued op completes normally.
    ackMode = ACK_NEVER;
    base = readyHighCnt;
    pushOp(16'h0001, 16'h0001, FUNC_ADD);
    pushOp(16'h1234, 16'h0000, FUNC_IDA);
    req_valid = 1'b0;
    waitResult("timeout");
    ackMode = ACK_PULSE;
    check("timeout alu_ready cycles", readyHighCnt - base, 15);
    check("timeout data", res_data, 16'h0000);
    check("timeout err", res_err, 1);
    acceptResult();
    getResult("after timeout", 16'h1234, 1'b0);

    // ALU holds ack 4 cycles past alu_ready drop.
    ackMode = ACK_HOLD;
    badBase = badRiseCnt;
    pushOp(16'h0010, 16'h0020, FUNC_ADD);
    t0 = pushCyc;
    pushOp(16'h0001, 16'h0001, FUNC_ADD);
    req_valid = 1'b0;
    waitResult("hold");
    check("hold latency", resCyc - t0, 9);
    check("hold data", res_data, 16'h0030);
    acceptResult();
    getResult("hold second", 16'h0002, 1'b0);
    check("hold no rise during ack", badRiseCnt - badBase, 0);
    ackMode = ACK_PULSE;
    repeat (8) @(negedge clk);

    // Reset while waiting on the ALU, with a second request queued.
    ackMode = ACK_NEVER;
    pushOp(16'h0001, 16'h0002, FUNC_ADD);
    pushOp(16'h0003, 16'h0004, FUNC_SUB);
    req_valid = 1'b0;
    for (int n = 0; n < 20 && !alu_ready; n++) @(negedge clk);
    check("pre-reset alu_ready", alu_ready, 1);
    #2 reset_n = 1'b0;
    #1;
    check("async reset alu_ready", alu_ready, 0);
    check("async reset res_valid", res_valid, 0);
    check("async reset busy", busy, 0);
    check("async reset req_ready", req_ready, 1);
    @(negedge clk);
    reset_n = 1'b1;
    ackMode = ACK_PULSE;
    rises = readyRiseCnt;
    repeat (10) @(negedge clk);
    check("post-reset queue empty", readyRiseCnt - rises, 0);
    check("post-reset res_valid", res_valid, 0);
    check("post-reset busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
